// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester/memory bus bundle for mem_arbiter
// Signal suffixes are relative to the arbiter: _i driven by master, _o driven by the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
);
  logic              ic_rqst_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              dc_rqst_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              mem_rqst_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              ic_ready_o;
  logic              dc_ready_o;
  logic [ADDR_W-1:0] resp_addr_o;
  logic [LINE_W-1:0] resp_data_o;
  logic              busy_o;

  modport slave (
    input  ic_rqst_i, ic_addr_i, dc_rqst_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rdata_i,
    output mem_rqst_o, mem_we_o, mem_addr_o, mem_wdata_o,
           ic_ready_o, dc_ready_o, resp_addr_o, resp_data_o, busy_o
  );

  modport master (
    output ic_rqst_i, ic_addr_i, dc_rqst_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rdata_i,
    input  mem_rqst_o, mem_we_o, mem_addr_o, mem_wdata_o,
           ic_ready_o, dc_ready_o, resp_addr_o, resp_data_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache line arbiter in front of a single memory port
// ARB_ROUND_ROBIN_EN: alternate grants on contention; undefined gives fixed dcache-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic              ic_pend_q, ic_pend_d;
  logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
  logic              dc_pend_q, dc_pend_d;
  logic              dc_we_q, dc_we_d;
  logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
  logic [LINE_W-1:0] dc_wdata_q, dc_wdata_d;
  logic              grant_dc_q, grant_dc_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_dc_q, last_dc_d;
`endif

  logic              pick_dc;
  logic              ic_take;
  logic              dc_take;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_dc = dc_pend_q && (!ic_pend_q || !last_dc_q);
`else
  assign pick_dc = dc_pend_q;
`endif

  // The requester being answered this cycle may re-request; its pending bit is about to clear.
  assign ic_take  = bus.ic_rqst_i && (!ic_pend_q || (state_q == RESP && !grant_dc_q));
  assign dc_take  = bus.dc_rqst_i && (!dc_pend_q || (state_q == RESP && grant_dc_q));
  assign cur_addr = grant_dc_q ? dc_addr_q : ic_addr_q;
  assign cur_we   = grant_dc_q && dc_we_q;

  always_comb begin
    state_d     = state_q;
    ic_pend_d   = ic_pend_q;
    ic_addr_d   = ic_addr_q;
    dc_pend_d   = dc_pend_q;
    dc_we_d     = dc_we_q;
    dc_addr_d   = dc_addr_q;
    dc_wdata_d  = dc_wdata_q;
    grant_dc_d  = grant_dc_q;
    resp_addr_d = resp_addr_q;
    resp_data_d = resp_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dc_d   = last_dc_q;
`endif
    case (state_q)
      IDLE: begin
        if (ic_pend_q || dc_pend_q) begin
          state_d    = BUSY;
          grant_dc_d = pick_dc;
`ifdef ARB_ROUND_ROBIN_EN
          last_dc_d  = pick_dc;
`endif
        end
      end
      BUSY: begin
        if (bus.mem_ready_i) begin
          state_d     = RESP;
          resp_addr_d = cur_addr;
          if (!cur_we) resp_data_d = bus.mem_rdata_i;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (grant_dc_q) dc_pend_d = 1'b0;
        else            ic_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Captures come after the clear so a re-request in RESP survives.
    if (ic_take) begin
      ic_pend_d = 1'b1;
      ic_addr_d = bus.ic_addr_i;
    end
    if (dc_take) begin
      dc_pend_d  = 1'b1;
      dc_we_d    = bus.dc_we_i;
      dc_addr_d  = bus.dc_addr_i;
      dc_wdata_d = bus.dc_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ic_pend_q   <= 1'b0;
      ic_addr_q   <= '0;
      dc_pend_q   <= 1'b0;
      dc_we_q     <= 1'b0;
      dc_addr_q   <= '0;
      dc_wdata_q  <= '0;
      grant_dc_q  <= 1'b0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dc_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      ic_pend_q   <= ic_pend_d;
      ic_addr_q   <= ic_addr_d;
      dc_pend_q   <= dc_pend_d;
      dc_we_q     <= dc_we_d;
      dc_addr_q   <= dc_addr_d;
      dc_wdata_q  <= dc_wdata_d;
      grant_dc_q  <= grant_dc_d;
      resp_addr_q <= resp_addr_d;
      resp_data_q <= resp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dc_q   <= last_dc_d;
`endif
    end
  end

  assign bus.mem_rqst_o  = (state_q == BUSY);
  assign bus.mem_we_o    = (state_q == BUSY) && cur_we;
  assign bus.mem_addr_o  = (state_q == BUSY) ? cur_addr : '0;
  assign bus.mem_wdata_o = ((state_q == BUSY) && grant_dc_q) ? dc_wdata_q : '0;
  assign bus.ic_ready_o  = (state_q == RESP) && !grant_dc_q;
  assign bus.dc_ready_o  = (state_q == RESP) && grant_dc_q;
  assign bus.resp_addr_o = resp_addr_q;
  assign bus.resp_data_o = resp_data_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 20;
  localparam int LW = 128;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Spec arbitration rule given the registered pending set and the previous grant.
  function automatic bit pick_dc(bit icv, bit dcv, bit last_dc);
    if (!icv) return 1'b1;
    if (!dcv) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_dc;
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_inputs();
    bus.ic_rqst_i   = 1'b0;
    bus.ic_addr_i   = '0;
    bus.dc_rqst_i   = 1'b0;
    bus.dc_we_i     = 1'b0;
    bus.dc_addr_i   = '0;
    bus.dc_wdata_i  = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h00AAA;
    bus.dc_rqst_i = 1'b1; bus.dc_addr_i = 20'h00BBB; bus.dc_we_i = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL rst_rqst got=%0b exp=0", bus.mem_rqst_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got=%0b exp=0", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata_o); end
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {bus.ic_ready_o, bus.dc_ready_o}); end
    checks++; if (bus.resp_addr_o !== '0) begin errors++; $display("FAIL rst_resp_addr got=%h exp=0", bus.resp_addr_o); end
    checks++; if (bus.resp_data_o !== '0) begin errors++; $display("FAIL rst_resp_data got=%h exp=0", bus.resp_data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", bus.busy_o); end
    // Pulses presented during reset must have been dropped.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL rst_drop cyc=%0d got=%0b exp=0", i, bus.mem_rqst_o); end
    end
  endtask

  task automatic test_single_read();
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    do_reset();
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h01230;
    @(negedge clk);
    bus.ic_rqst_i = 1'b0; bus.ic_addr_i = 20'h0DEAD;
    checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL sr_rqst_n1 got=%0b exp=0", bus.mem_rqst_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL sr_rqst cyc=%0d got=%0b exp=1", i, bus.mem_rqst_o); end
      checks++; if (bus.mem_addr_o !== 20'h01230) begin errors++; $display("FAIL sr_addr got=%h exp=01230", bus.mem_addr_o); end
      checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sr_we got=%0b exp=0", bus.mem_we_o); end
    end
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = a5;
    @(negedge clk);
    bus.mem_ready_i = 1'b0; bus.mem_rdata_i = rand_line();
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== 2'b10) begin errors++; $display("FAIL sr_ready got=%b exp=10", {bus.ic_ready_o, bus.dc_ready_o}); end
    checks++; if (bus.resp_addr_o !== 20'h01230) begin errors++; $display("FAIL sr_resp_addr got=%h exp=01230", bus.resp_addr_o); end
    checks++; if (bus.resp_data_o !== a5) begin errors++; $display("FAIL sr_resp_data got=%h exp=%h", bus.resp_data_o, a5); end
    checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL sr_rqst_resp got=%0b exp=0", bus.mem_rqst_o); end
    @(negedge clk);
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o, bus.busy_o} !== 3'b000) begin errors++; $display("FAIL sr_after got=%b exp=000", {bus.ic_ready_o, bus.dc_ready_o, bus.busy_o}); end
    checks++; if (bus.resp_data_o !== a5) begin errors++; $display("FAIL sr_hold got=%h exp=%h", bus.resp_data_o, a5); end
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] a_first, a_second;
    logic [LW-1:0] r1, r2;
    bit            first_dc;
`ifdef ARB_ROUND_ROBIN_EN
    first_dc = 1'b0;
`else
    first_dc = 1'b1;
`endif
    a_first  = first_dc ? 20'h00200 : 20'h00100;
    a_second = first_dc ? 20'h00100 : 20'h00200;
    r1 = rand_line();
    r2 = rand_line();
    do_reset();
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h00100;
    bus.dc_rqst_i = 1'b1; bus.dc_addr_i = 20'h00200; bus.dc_we_i = 1'b0;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.mem_addr_o !== a_first || bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL sim_first got=%h/%0b exp=%h/1", bus.mem_addr_o, bus.mem_rqst_o, a_first); end
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = r1;
    @(negedge clk);
    clear_inputs();
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== {!first_dc, first_dc}) begin errors++; $display("FAIL sim_ready1 got=%b exp=%b", {bus.ic_ready_o, bus.dc_ready_o}, {!first_dc, first_dc}); end
    checks++; if (bus.resp_data_o !== r1) begin errors++; $display("FAIL sim_data1 got=%h exp=%h", bus.resp_data_o, r1); end
    @(negedge clk);
    checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL sim_gap got=%0b exp=0", bus.mem_rqst_o); end
    @(negedge clk);
    checks++; if (bus.mem_addr_o !== a_second || bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL sim_second got=%h/%0b exp=%h/1", bus.mem_addr_o, bus.mem_rqst_o, a_second); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sim_we got=%0b exp=0", bus.mem_we_o); end
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = r2;
    @(negedge clk);
    clear_inputs();
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== {first_dc, !first_dc}) begin errors++; $display("FAIL sim_ready2 got=%b exp=%b", {bus.ic_ready_o, bus.dc_ready_o}, {first_dc, !first_dc}); end
    checks++; if (bus.resp_addr_o !== a_second || bus.resp_data_o !== r2) begin errors++; $display("FAIL sim_resp2 got=%h/%h exp=%h/%h", bus.resp_addr_o, bus.resp_data_o, a_second, r2); end
  endtask

  task automatic test_writeback();
    logic [LW-1:0] wd;
    wd = 128'h1234;
    do_reset();
    bus.dc_rqst_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_addr_i = 20'h0FFF0; bus.dc_wdata_i = wd;
    @(negedge clk);
    clear_inputs();
    bus.dc_wdata_i = rand_line();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL wb_we cyc=%0d got=%0b/%0b exp=1/1", i, bus.mem_we_o, bus.mem_rqst_o); end
      checks++; if (bus.mem_wdata_o !== wd || bus.mem_addr_o !== 20'h0FFF0) begin errors++; $display("FAIL wb_data got=%h/%h exp=%h/0fff0", bus.mem_wdata_o, bus.mem_addr_o, wd); end
    end
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = rand_line();
    @(negedge clk);
    clear_inputs();
    checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== 2'b01) begin errors++; $display("FAIL wb_ready got=%b exp=01", {bus.ic_ready_o, bus.dc_ready_o}); end
    checks++; if (bus.resp_data_o !== '0) begin errors++; $display("FAIL wb_resp_data got=%h exp=0", bus.resp_data_o); end
    checks++; if (bus.resp_addr_o !== 20'h0FFF0) begin errors++; $display("FAIL wb_resp_addr got=%h exp=0fff0", bus.resp_addr_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL wb_we_after got=%0b exp=0", bus.mem_we_o); end
  endtask

  task automatic test_duplicate();
    do_reset();
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h00010;
    @(negedge clk);
    bus.ic_addr_i = 20'h00040;
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.mem_addr_o !== 20'h00010 || bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL dup_first got=%h/%0b exp=00010/1", bus.mem_addr_o, bus.mem_rqst_o); end
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.ic_ready_o !== 1'b1 || bus.resp_addr_o !== 20'h00010) begin errors++; $display("FAIL dup_resp got=%0b/%h exp=1/00010", bus.ic_ready_o, bus.resp_addr_o); end
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h00050;
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL dup_idle got=%0b exp=0", bus.busy_o); end
    @(negedge clk);
    checks++; if (bus.mem_addr_o !== 20'h00050 || bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL dup_second got=%h/%0b exp=00050/1", bus.mem_addr_o, bus.mem_rqst_o); end
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.resp_addr_o !== 20'h00050) begin errors++; $display("FAIL dup_resp2 got=%h exp=00050", bus.resp_addr_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_rqst_o !== 1'b0) begin errors++; $display("FAIL dup_extra cyc=%0d got=%0b exp=0", i, bus.mem_rqst_o); end
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.ic_rqst_i = 1'b1; bus.ic_addr_i = 20'h00777;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.mem_rqst_o !== 1'b1) begin errors++; $display("FAIL rb_busy got=%0b exp=1", bus.mem_rqst_o); end
    rst = 1'b1;
    bus.dc_rqst_i = 1'b1; bus.dc_addr_i = 20'h00888;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    checks++; if (bus.mem_rqst_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rb_after got=%0b/%0b exp=0/0", bus.mem_rqst_o, bus.busy_o); end
    @(negedge clk);
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = rand_line();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      checks++; if ({bus.ic_ready_o, bus.dc_ready_o, bus.mem_rqst_o, bus.busy_o} !== 4'b0000) begin errors++; $display("FAIL rb_quiet cyc=%0d got=%b exp=0000", i, {bus.ic_ready_o, bus.dc_ready_o, bus.mem_rqst_o, bus.busy_o}); end
      checks++; if (bus.resp_data_o !== '0) begin errors++; $display("FAIL rb_data got=%h exp=0", bus.resp_data_o); end
    end
  endtask

  // Cycle-level reference: pending slots, a three-phase transaction view and the response registers.
  task automatic test_random();
    bit            ic_v, dc_v, dc_we, last_dc, g_dc, ic_p, dc_p, rdy, srv_ic, srv_dc;
    logic [AW-1:0] ic_a, dc_a, raddr, n_ic_a, n_dc_a;
    logic [LW-1:0] dc_wd, rdata, n_dc_wd, drv_rdata;
    bit            n_dc_we;
    int            phase, old_phase, wait_cnt;
    do_reset();
    ic_v = 0; dc_v = 0; dc_we = 0; last_dc = 1; g_dc = 0;
    ic_a = '0; dc_a = '0; dc_wd = '0; raddr = '0; rdata = '0;
    phase = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      checks++; if (bus.mem_rqst_o !== (phase == 1)) begin errors++; $display("FAIL rnd_rqst cyc=%0d got=%0b exp=%0b", cyc, bus.mem_rqst_o, phase == 1); end
      checks++; if (bus.busy_o !== (phase != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, bus.busy_o, phase != 0); end
      checks++; if ({bus.ic_ready_o, bus.dc_ready_o} !== {phase == 2 && !g_dc, phase == 2 && g_dc}) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {bus.ic_ready_o, bus.dc_ready_o}, {phase == 2 && !g_dc, phase == 2 && g_dc}); end
      checks++; if (bus.resp_addr_o !== raddr || bus.resp_data_o !== rdata) begin errors++; $display("FAIL rnd_resp cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.resp_addr_o, bus.resp_data_o, raddr, rdata); end
      if (phase == 1) begin
        checks++; if (bus.mem_addr_o !== (g_dc ? dc_a : ic_a) || bus.mem_we_o !== (g_dc && dc_we)) begin errors++; $display("FAIL rnd_mem cyc=%0d got=%h/%0b exp=%h/%0b", cyc, bus.mem_addr_o, bus.mem_we_o, g_dc ? dc_a : ic_a, g_dc && dc_we); end
        if (g_dc && dc_we) begin
          checks++; if (bus.mem_wdata_o !== dc_wd) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata_o, dc_wd); end
        end
      end
      ic_p = ($urandom_range(0, 4) == 0);
      dc_p = ($urandom_range(0, 4) == 0);
      n_ic_a = AW'($urandom);
      n_dc_a = AW'($urandom);
      n_dc_we = $urandom_range(0, 1);
      n_dc_wd = rand_line();
      drv_rdata = rand_line();
      if (phase == 1) rdy = (wait_cnt == 0);
      else            rdy = ($urandom_range(0, 5) == 0);
      bus.ic_rqst_i = ic_p; bus.ic_addr_i = n_ic_a;
      bus.dc_rqst_i = dc_p; bus.dc_addr_i = n_dc_a; bus.dc_we_i = n_dc_we; bus.dc_wdata_i = n_dc_wd;
      bus.mem_ready_i = rdy; bus.mem_rdata_i = drv_rdata;
      old_phase = phase;
      srv_ic = (old_phase == 2) && !g_dc;
      srv_dc = (old_phase == 2) && g_dc;
      case (old_phase)
        0: if (ic_v || dc_v) begin
             g_dc = pick_dc(ic_v, dc_v, last_dc);
             last_dc = g_dc;
             phase = 1;
             wait_cnt = $urandom_range(0, 3);
           end
        1: if (rdy) begin
             raddr = g_dc ? dc_a : ic_a;
             if (!(g_dc && dc_we)) rdata = drv_rdata;
             phase = 2;
           end else wait_cnt--;
        default: phase = 0;
      endcase
      if (ic_p && (!ic_v || srv_ic)) begin ic_v = 1; ic_a = n_ic_a; end
      else if (srv_ic) ic_v = 0;
      if (dc_p && (!dc_v || srv_dc)) begin dc_v = 1; dc_a = n_dc_a; dc_we = n_dc_we; dc_wd = n_dc_wd; end
      else if (srv_dc) dc_v = 0;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_writeback();
    test_duplicate();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 20, line/byte address width; LINE_W, 128, cache line width.
REQ-002 SHALL have ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ic_rqst_i  in  1  icache miss request pulse (read only).
- ic_addr_i  in  ADDR_W  icache request address.
- dc_rqst_i  in  1  dcache request pulse.
- dc_we_i  in  1  dcache request is a line write-back.
- dc_addr_i  in  ADDR_W  dcache request address.
- dc_wdata_i  in  LINE_W  dcache write-back line.
- mem_rqst_o  out  1  memory request, held until mem_ready_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_ready_i  in  1  memory completion, one-cycle pulse.
- mem_rdata_i  in  LINE_W  memory read line, valid with mem_ready_i.
- ic_ready_o  out  1  icache response pulse.
- dc_ready_o  out  1  dcache response pulse.
- resp_addr_o  out  ADDR_W  address of the completed request.
- resp_data_o  out  LINE_W  line returned for a completed read.
- busy_o  out  1  high while state is not IDLE.

Function
REQ-003 SHALL latch each requester's rqst_i pulse into a per-requester pending bit, together with addr (and we/wdata for dcache), on the same edge.
REQ-004 SHALL ignore a rqst_i pulse from a requester whose pending bit is already set; the latched request SHALL be unchanged.
REQ-005 SHALL implement states IDLE, BUSY, RESP; reset state IDLE.
REQ-006 IDLE: if any pending bit is set (as registered, not same-cycle input), grant one per REQ-015 and go to BUSY next cycle; otherwise stay IDLE.
REQ-007 BUSY: mem_rqst_o=1, mem_addr_o/mem_we_o/mem_wdata_o driven from the granted latch, stable until mem_ready_i; on mem_ready_i go to RESP.
REQ-008 mem_we_o SHALL be 1 only for a granted dcache write-back; icache grants always read.
REQ-009 RESP: exactly one of ic_ready_o/dc_ready_o SHALL be 1 for one cycle; resp_addr_o=granted address; resp_data_o=mem_rdata_i registered at the completing edge (for writes resp_data_o holds its previous value); the granted pending bit is cleared; next state IDLE.
REQ-010 Latency: request pulse at cycle N with arbiter idle -> mem_rqst_o high at N+2; mem_ready_i at cycle M -> ready_o at M+1; next grant no earlier than M+3.
REQ-011 A new rqst_i from the requester being served, arriving in the RESP cycle, SHALL be captured (set wins over clear).
REQ-012 mem_ready_i outside BUSY SHALL be ignored.
REQ-013 resp_addr_o and resp_data_o SHALL hold their values outside RESP.

Reset
REQ-014 On rst_i=1 at a rising edge: state IDLE, pending bits 0, all latched addr/data 0, mem_rqst_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, ic_ready_o=0, dc_ready_o=0, resp_addr_o=0, resp_data_o=0, busy_o=0, last-grant=dcache. Reset during BUSY abandons the transaction, and mem_rqst_o is 0 the following cycle. rqst_i pulses in the reset cycle are dropped.

Configuration
REQ-015 Macro ARB_ROUND_ROBIN_EN: defined -> when both requesters are pending, grant the one not granted last (last-grant register updated on each grant, reset = dcache, so icache wins first); undefined -> fixed priority, dcache always wins, no last-grant register.

Verification
REQ-016 Single icache read: ic_rqst_i pulse, addr 0x01230, mem_ready_i 3 cycles after mem_rqst_o with rdata 0xA5..A5 -> ic_ready_o one cycle, resp_addr_o=0x01230, resp_data_o=0xA5..A5, mem_we_o=0 throughout.
REQ-017 Simultaneous ic/dc pulses, dc read: with ARB_ROUND_ROBIN_EN icache served first, then dcache; without it, dcache first; second request's mem_rqst_o exactly 2 cycles after the first's ready pulse.
REQ-018 Dcache write-back addr 0x0FFF0, wdata 0x1234 -> mem_we_o=1, mem_wdata_o=0x1234 held until mem_ready_i; dc_ready_o pulses; resp_data_o unchanged.
REQ-019 Duplicate ic_rqst_i with addr 0x00040 while icache pending on 0x00010 -> only 0x00010 issued; a pulse in the RESP cycle with addr 0x00050 -> 0x00050 issued next.
REQ-020 rst_i asserted in BUSY, then mem_ready_i pulse 2 cycles later -> mem_rqst_o=0 after reset edge, no ready_o pulses, busy_o=0, state IDLE.
